// File: rtl/div_sequencer_if.sv
// Purpose: bundles the request/response and divider-core signals of div_sequencer.
// Ports  : start/signed_op/op_a/op_b in, busy/done/result/div_by_zero out (request side);
//          core_dividend/core_divisor out, core_quotient in (core side).
// Modports: master = ALU/decode side plus core model, slave = the sequencer itself.
interface div_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  logic [WIDTH-1:0] core_dividend;
  logic [WIDTH-1:0] core_divisor;
  logic [WIDTH-1:0] core_quotient;

  modport slave (
    input  start, signed_op, op_a, op_b, core_quotient,
    output busy, done, result, div_by_zero, core_dividend, core_divisor
  );

  modport master (
    output start, signed_op, op_a, op_b, core_quotient,
    input  busy, done, result, div_by_zero, core_dividend, core_divisor
  );
endinterface

// File: rtl/div_sequencer.sv
// Purpose: multi-cycle control around a combinational restoring divider core; takes a
//          signed/unsigned request, feeds the core magnitudes, sign-corrects the quotient.
// Latency: done one cycle after the start edge + SETTLE_CYCLES; divide-by-zero done the
//          cycle right after the start edge. Starts outside IDLE are dropped (no queuing).
// Ports  : clk, reset (async, active-high); bus (div_sequencer_if.slave) carries the
//          request/result handshake and the core operand/quotient signals.
module div_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic           clk,
  input  logic           reset,
  div_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]       CNT_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;

  // Two's-complement magnitude; the most negative value maps onto itself, which is
  // still the right magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + ONE) : x;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op_b == '0) begin
            // Core is bypassed entirely; its operand registers keep the last job.
            result_d = '1;
            dbz_d    = 1'b1;
            state_d  = S_DONE;
          end else begin
            dvd_d   = bus.signed_op ? mag(bus.op_a) : bus.op_a;
            dvs_d   = bus.signed_op ? mag(bus.op_b) : bus.op_b;
            neg_d   = bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            cnt_d   = CNT_LOAD;
            dbz_d   = 1'b0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          // Negation wraps, so 0x8000 / -1 comes back as 0x8000 with no flag.
          result_d = neg_q ? (~bus.core_quotient + ONE) : bus.core_quotient;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      neg_q    <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
    end
  end

  assign bus.busy          = (state_q == S_WAIT);
  assign bus.done          = (state_q == S_DONE);
  assign bus.result        = result_q;
  assign bus.div_by_zero   = dbz_q;
  assign bus.core_dividend = dvd_q;
  assign bus.core_divisor  = dvs_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Purpose: directed + random checks of div_sequencer against a scoreboard of expected
//          quotients, with a behavioural model of the combinational divider core.
// Ports  : none (top-level bench).
module tb_div_sequencer;
  localparam int W = 16;
  localparam int S = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_pulses = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(W)) bus();

  div_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Combinational divider core model.
  assign bus.core_quotient = (bus.core_divisor == '0) ? '1 : (bus.core_dividend / bus.core_divisor);

  always @(negedge clk) if (bus.done === 1'b1) done_pulses++;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int          na, nb;
    logic [31:0] q;
    if (b == '0) return '1;
    na = s ? int'($signed(a)) : int'(a);
    nb = s ? int'($signed(b)) : int'(b);
    q  = 32'(na / nb);
    return q[W-1:0];
  endfunction

  // Issues one request at the current (IDLE) cycle and follows it to the cycle after done.
  // ignore_at != 0 pulses start with fresh operands in that WAIT cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_res, input int ignore_at);
    exp_t         e;
    int           busy_n;
    int           lat;
    int           p0;
    logic         dz;
    logic [W-1:0] ea, eb;
    dz = (b == '0);
    ea = (s && a[W-1]) ? (W'(0) - a) : a;
    eb = (s && b[W-1]) ? (W'(0) - b) : b;
    e.res = exp_res;
    e.dbz = dz;
    sb.push_back(e);
    p0 = done_pulses;

    bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.signed_op = s;
    tick();
    bus.start = 1'b0;
    if (!dz) begin
      check({tag, "_core_dividend"}, 32'(bus.core_dividend), 32'(ea));
      check({tag, "_core_divisor"},  32'(bus.core_divisor),  32'(eb));
    end

    busy_n = 0;
    lat    = 1;
    while (bus.done !== 1'b1 && lat < 300) begin
      if (bus.busy === 1'b1) busy_n++;
      if (ignore_at != 0 && busy_n == ignore_at) begin
        bus.start = 1'b1; bus.op_a = 16'h0064; bus.op_b = 16'h0005; bus.signed_op = 1'b0;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;

    check({tag, "_done"},     32'(bus.done), 32'd1);
    check({tag, "_latency"},  32'(lat),      dz ? 32'd1 : 32'(S + 1));
    check({tag, "_busy_cyc"}, 32'(busy_n),   dz ? 32'd0 : 32'(S));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, 32'(bus.result),      32'(e.res));
      check({tag, "_dbz"},    32'(bus.div_by_zero), 32'(e.dbz));
    end

    tick();
    check({tag, "_done_low"},    32'(bus.done),          32'd0);
    check({tag, "_busy_low"},    32'(bus.busy),          32'd0);
    check({tag, "_result_hold"}, 32'(bus.result),        32'(exp_res));
    check({tag, "_pulses"},      32'(done_pulses - p0),  32'd1);
  endtask

  initial begin
    int           p0;
    logic [W-1:0] ra, rb;
    logic         rs;

    reset = 1'b1;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.op_a = '0; bus.op_b = '0;
    tick();
    tick();
    check("rst_busy",   32'(bus.busy),          32'd0);
    check("rst_done",   32'(bus.done),          32'd0);
    check("rst_result", 32'(bus.result),        32'd0);
    check("rst_dbz",    32'(bus.div_by_zero),   32'd0);
    check("rst_cdvd",   32'(bus.core_dividend), 32'd0);
    check("rst_cdvs",   32'(bus.core_divisor),  32'd0);
    reset = 1'b0;
    tick();

    run_op("unsigned",      16'h0F00, 16'h0100, 1'b0, 16'h000F, 0);
    run_op("signed",        16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 0);
    run_op("unsigned_same", 16'hFF9C, 16'h0007, 1'b0, 16'h2484, 0);
    run_op("div0",          16'h1234, 16'h0000, 1'b0, 16'hFFFF, 0);
    run_op("overflow",      16'h8000, 16'hFFFF, 1'b1, 16'h8000, 3);
    tick();
    tick();
    check("ovf_hold_result", 32'(bus.result),      32'h8000);
    check("ovf_hold_dbz",    32'(bus.div_by_zero), 32'd0);
    check("ovf_hold_busy",   32'(bus.busy),        32'd0);

    // Reset in the 4th WAIT cycle.
    p0 = done_pulses;
    bus.start = 1'b1; bus.op_a = 16'h0F00; bus.op_b = 16'h0100; bus.signed_op = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy",   32'(bus.busy),          32'd0);
    check("mid_rst_done",   32'(bus.done),          32'd0);
    check("mid_rst_result", 32'(bus.result),        32'd0);
    check("mid_rst_dbz",    32'(bus.div_by_zero),   32'd0);
    check("mid_rst_cdvd",   32'(bus.core_dividend), 32'd0);
    check("mid_rst_cdvs",   32'(bus.core_divisor),  32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("mid_rst_no_done", 32'(done_pulses - p0), 32'd0);
    run_op("after_rst", 16'h0F00, 16'h0100, 1'b0, 16'h000F, 0);

    // run_op returns in the first IDLE cycle after done, so this is back-to-back.
    run_op("b2b_first",  16'h0F00, 16'h0100, 1'b0, 16'h000F, 0);
    run_op("b2b_second", 16'h0064, 16'h000A, 1'b0, 16'h000A, 0);

    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom_range(0, 300));
      if ($urandom_range(0, 1) == 1) rb = W'(0) - rb;
      rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
